// File: rtl/fifo_stream_pkg.sv
// Shared types and constants for the FIFO read streamer.
package fifo_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  // Output skid buffer depth: covers one word in flight plus pipelining slack
  localparam int BUF_DEPTH = 3;
  localparam int CNT_W     = 2;

endpackage

// File: rtl/fifo_stream_buf.sv
// Three-entry ordered buffer between the FIFO read port and the stream output.
// The oldest entry is presented combinationally so the stream sees it at once.
module fifo_stream_buf
  import fifo_stream_pkg::*;
#(
  parameter int data_width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [data_width-1:0] push_data,
  input  logic                  pop,
  output logic [data_width-1:0] pop_data,
  output logic [CNT_W-1:0]      count
);

  logic [data_width-1:0] mem_reg [BUF_DEPTH];
  logic [CNT_W-1:0]      wr_ptr_reg;
  logic [CNT_W-1:0]      rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg;
  logic                  pop_ok;

  localparam logic [CNT_W-1:0] LAST_PTR = CNT_W'(BUF_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);

  // A pop on an empty buffer is ignored rather than corrupting the pointers
  assign pop_ok   = pop && (count_reg != '0);
  assign pop_data = mem_reg[rd_ptr_reg];
  assign count    = count_reg;

  // Storage array: no reset, contents are only meaningful while counted
  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  // Pointer and occupancy tracking; simultaneous push and pop keeps count
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
      end
      case ({push, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      // The issue logic upstream reserves a slot for every pop in flight
      assert (!(push && !pop_ok && (count_reg == FULL_CNT)));
    end
  end

endmodule

// File: rtl/fifo_read_streamer.sv
// Pulls words from the read side of an asynchronous FIFO (1-cycle read latency)
// and presents them as a valid/ready stream with a last flag every burst_len beats.
module fifo_read_streamer
  import fifo_stream_pkg::*;
#(
  parameter int data_width = 8,
  parameter int burst_len  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  output logic                  fifo_read,
  input  logic [data_width-1:0] fifo_read_data,
  input  logic                  fifo_read_empty,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [data_width-1:0] out_data,
  output logic                  out_last,
  output logic                  busy
);

  localparam int BEAT_W = (burst_len > 1) ? $clog2(burst_len) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(burst_len - 1);

  state_t            state_reg;
  state_t            state_next;
  logic              inflight_reg;
  logic [BEAT_W-1:0] beat_cnt_reg;
  logic [CNT_W-1:0]  buf_count;
  logic              handshake;

  // Pop only while ACTIVE and only if the word already in flight still has room;
  // deliberately independent of out_ready to keep the FIFO path short
  assign fifo_read = (state_reg == ACTIVE) && !fifo_read_empty &&
                     (({1'b0, buf_count} + {2'b00, inflight_reg}) < 3'(BUF_DEPTH));

  assign out_valid = (buf_count != '0);
  assign handshake = out_valid && out_ready;
  assign out_last  = (beat_cnt_reg == LAST_BEAT);
  assign busy      = (state_reg != IDLE) || inflight_reg || (buf_count != '0);

  // Next-state logic; DRAIN waits only for the last pop to land
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (enable) state_next = ACTIVE;
      ACTIVE:  if (!enable) state_next = DRAIN;
      DRAIN: begin
        if (enable) begin
          state_next = ACTIVE;
        end else if (!inflight_reg) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register and in-flight flag (a reset drops any word still in flight)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      inflight_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      inflight_reg <= fifo_read;
    end
  end

  // Beat counter advances per handshake and is unaffected by enable gaps
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_reg <= '0;
    end else if (handshake) begin
      beat_cnt_reg <= (beat_cnt_reg == LAST_BEAT) ? '0 : beat_cnt_reg + 1'b1;
    end
  end

  fifo_stream_buf #(
    .data_width(data_width)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight_reg),
    .push_data(fifo_read_data),
    .pop      (handshake),
    .pop_data (out_data),
    .count    (buf_count)
  );

endmodule
